// File: rtl/aesl_deadlock_report_ctrl.sv
// aesl_deadlock_report_ctrl: watches the deadlock monitor's block flag while the
// DUT is running, declares deadlock after THRESH consecutive blocked cycles, then
// emits one valid/ready report beat per blocked channel.
// Optional feature macro: AESL_DEADLOCK_SNAPSHOT_EN (freeze block info at deadlock).
module aesl_deadlock_report_ctrl #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned THRESH = 1024,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned INFO_W = 3 * NUM_CH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dut_start,
    input  logic              dut_done,
    input  logic              block,
    input  logic [INFO_W-1:0] axis_block_info,
    input  logic              clear,
    output logic              report_valid,
    input  logic              report_ready,
    output logic [IDX_W-1:0]  report_ch,
    output logic [2:0]        report_code,
    output logic              report_done,
    output logic              deadlock
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_REPORT = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   ch_q, ch_d;
    logic [2:0]         code_q, code_d;
    logic               done_q, done_d;
    logic               dl_q, dl_d;
    logic [INFO_W-1:0]  scan_info_c;
    logic [2:0]         field_c;
    logic               is_last_c;
    logic               hit_c;

    assign is_last_c = (idx_q == IDX_W'(NUM_CH - 1));
    assign hit_c     = block && (cnt_q == CNT_W'(THRESH - 1));

`ifdef AESL_DEADLOCK_SNAPSHOT_EN
    logic [INFO_W-1:0] snap_q;

    // Capture the block info on the cycle deadlock is declared
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_q <= '0;
        end else if (!clear && state_q == ST_ARMED && hit_c) begin
            snap_q <= axis_block_info;
        end
    end

    assign scan_info_c = snap_q;
`else
    assign scan_info_c = axis_block_info;
`endif

    // Select the 3-bit code of the channel currently being scanned
    always_comb begin
        field_c = 3'b000;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                field_c = scan_info_c[3*i +: 3];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            code_q  <= 3'b000;
            done_q  <= 1'b0;
            dl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            code_q  <= code_d;
            done_q  <= done_d;
            dl_q    <= dl_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        logic adv;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ch_d    = ch_q;
        code_d  = code_q;
        done_d  = 1'b0;
        dl_d    = dl_q;
        adv     = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            ch_d    = '0;
            code_d  = 3'b000;
            dl_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (dut_start) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (block) begin
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                    // Deadlock takes priority over a simultaneous dut_done
                    if (hit_c) begin
                        state_d = ST_REPORT;
                        idx_d   = '0;
                        dl_d    = 1'b1;
                    end else if (dut_done) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_REPORT: begin
                    if (valid_q) begin
                        if (report_ready) begin
                            valid_d = 1'b0;
                            adv     = 1'b1;
                        end
                    end else if (field_c != 3'b000) begin
                        valid_d = 1'b1;
                        ch_d    = idx_q;
                        code_d  = field_c;
                    end else begin
                        adv = 1'b1;
                    end
                    if (adv) begin
                        if (is_last_c) begin
                            state_d = ST_HALT;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    // HALT: stay here until clear or reset
                end
            endcase
        end
    end

    assign report_valid = valid_q;
    assign report_ch    = ch_q;
    assign report_code  = code_q;
    assign report_done  = done_q;
    assign deadlock     = dl_q;

endmodule
